axi_id_remap_table: RTL and testbench
=====================================

# axi_id_remap_table

Tracking AXI ID remapper placed between a wide-ID AXI master fabric and a narrow-ID slave port, for example the NPU DMA in front of the DDR controller. It maps IN_ID_WIDTH-bit AR/AW IDs onto a table of 2**OUT_ID_WIDTH slots, one per distinct outstanding ID. It restores the original ID on R and B, and frees a slot when its last outstanding transaction completes. When no slot is available it back-pressures the AR or AW channel, so the slave never sees an ID collision. Per-ID ordering is preserved because every transaction with the same ID reuses the same slot.

## Interface
- IN_ID_WIDTH, 10, upstream ID width
- OUT_ID_WIDTH, 3, downstream ID width; table depth = 2**OUT_ID_WIDTH per channel
- CNT_WIDTH, 4, per-slot outstanding counter width; max 2**CNT_WIDTH-1 transactions per slot

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- s_arvalid / s_arready  in/out  1  upstream AR handshake
- s_arid  in  IN_ID_WIDTH  upstream AR ID
- m_arvalid / m_arready  out/in  1  downstream AR handshake
- m_arid  out  OUT_ID_WIDTH  remapped AR ID (slot index)
- s_awvalid, s_awready, s_awid, m_awvalid, m_awready, m_awid: same as AR, write side
- rvalid, rready, rlast  in  1  R handshake, observed only
- m_rid  in  OUT_ID_WIDTH  downstream R ID
- s_rid  out  IN_ID_WIDTH  restored R ID
- bvalid, bready  in  1  B handshake, observed only
- m_bid  in  OUT_ID_WIDTH  downstream B ID
- s_bid  out  IN_ID_WIDTH  restored B ID
- rd_full, wr_full  out  1  no free slot in the read / write table
- err_unmapped  out  1  sticky response-to-free-slot error

## Operation
- The read and write tables are independent. Each table slot holds: valid, stored in-ID, count[CNT_WIDTH].
- **Lookup** is combinational on the presented ID.
  - hit = a valid slot whose stored ID equals the presented ID.
  - free = lowest-index slot with valid == 0.
- **Grant** (read side): grant = hit ? (count != max) : free exists.
  - m_arvalid = s_arvalid & grant
  - s_arready = m_arready & grant
  - m_arid = hit slot if hit, else lowest free slot
- **AR handshake** (s_arvalid & s_arready):
  - On a hit: count++.
  - On a miss: the chosen slot gets valid = 1, ID stored, count = 1.
- **R completion** (rvalid & rready & rlast): count[m_rid]--. When count reaches 0, valid is cleared.
- s_rid = stored ID of slot m_rid, combinational.
- The write side is identical: B completion is bvalid & bready (no last); s_bid is looked up from m_bid.
- **Simultaneous allocate and free, same cycle:**
  - The allocation decision uses the pre-update table. A slot freed this cycle is not allocatable until the next cycle.
  - Same slot incremented and decremented: count unchanged, valid stays 1. This also holds when the pre-update count is 1.
- rd_full = all read slots valid. wr_full = all write slots valid.
- Reset mid-operation clears every table. Responses that arrive afterwards are the system's problem and are flagged if the error macro is enabled.

## Timing
- Zero-cycle latency: AR/AW and R/B are combinational pass-throughs. Table state updates on the clock edge of the handshake.
- The grant never depends on s_arvalid. m_arvalid may drop only when grant drops, which happens only through a table change caused by a handshake.
- Reset values:
  - All slots invalid, counts 0.
  - rd_full = wr_full = 0, err_unmapped = 0.
  - m_arvalid = s_arvalid, s_arready = m_arready.
  - s_rid = s_bid = 0.
- A counter underflow (completion on a count-0 slot) leaves the slot state unchanged.

## Configuration
- AXI_ID_REMAP_ERR_EN:
  - Defined: err_unmapped sets when an R-last or B completion hits a slot with valid == 0, and clears only on rst.
  - Undefined: err_unmapped is tied to 0 and the check logic is not built.

## Structure
- The shared package axi_id_remap_pkg holds:
  - the slot record typedef (valid, id, cnt);
  - the depth constant 2**OUT_ID_WIDTH;
  - the counter-max constant.
- Sub-module axi_id_remap_chan is one table with its lookup, allocate and free logic. The top level instantiates it twice (read, write).

## Test plan
- Single AR with arid=0x155 → m_arid=0. Then R with m_rid=0, rlast=1 → s_rid=0x155 and slot 0 freed.
- Three ARs with arid=0x001 and no responses → all m_arid=0, count=3. Three rlast beats → slot freed only after the third.
- 8 distinct ARs (OUT_ID_WIDTH=3) → slots 0..7 allocated, rd_full=1. A 9th, new ID is stalled (s_arready=0, m_arvalid=0). One rlast on slot 2 → the next cycle the 9th is accepted with m_arid=2.
- Same-ID AR and rlast in the same cycle on a count-1 slot → count stays 1, slot valid.
- 15 outstanding ARs with the same ID (CNT_WIDTH=4) → the 16th is stalled until one rlast completes.
- With AXI_ID_REMAP_ERR_EN: bvalid/bready on empty slot 5 → err_unmapped=1 from the next cycle and held until rst.

Source files
------------

// File: rtl/axi_id_remap_pkg.sv
// axi_id_remap_pkg: widths, table depth, counter limit and slot record shared by
// the AXI ID remapper. Optional feature macro: AXI_ID_REMAP_ERR_EN.
package axi_id_remap_pkg;

    localparam int unsigned IN_ID_W  = 32'd10;
    localparam int unsigned OUT_ID_W = 32'd3;
    localparam int unsigned CNT_W    = 32'd4;

    // One slot per downstream ID value
    localparam int unsigned DEPTH = 32'd1 << OUT_ID_W;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef logic [OUT_ID_W-1:0] slot_idx_t;

    typedef struct packed {
        logic               valid;
        logic [IN_ID_W-1:0] id;
        logic [CNT_W-1:0]   cnt;
    } slot_t;

    localparam slot_t SLOT_IDLE = '{valid: 1'b0, id: {IN_ID_W{1'b0}}, cnt: {CNT_W{1'b0}}};

    // Loop index to slot index
    function automatic slot_idx_t to_idx(input int unsigned i);
        return slot_idx_t'(i);
    endfunction

endpackage

// File: rtl/axi_id_remap_chan.sv
// axi_id_remap_chan: one remap table (read or write). Looks up the presented
// upstream ID, grants/allocates a slot, counts outstanding transactions per slot
// and frees the slot on its last completion. Optional: AXI_ID_REMAP_ERR_EN adds
// the completion-to-free-slot indication.
module axi_id_remap_chan
    import axi_id_remap_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IN_ID_W-1:0]  req_id,
    output logic                dn_valid,
    input  logic                dn_ready,
    output logic [OUT_ID_W-1:0] dn_id,
    input  logic                cpl_fire,
    input  logic [OUT_ID_W-1:0] cpl_slot,
    output logic [IN_ID_W-1:0]  rsp_id,
`ifdef AXI_ID_REMAP_ERR_EN
    output logic                unmapped,
`endif
    output logic                full
);

    slot_t            slot_r     [DEPTH];
    slot_t            slot_nxt_s [DEPTH];
    logic             hit_s;
    logic             free_found_s;
    logic             take_free_s;
    logic             grant_s;
    logic             alloc_fire_s;
    slot_idx_t        hit_idx_s;
    slot_idx_t        free_idx_s;
    slot_idx_t        alloc_idx_s;
    logic [DEPTH-1:0] valid_vec_s;
    logic [DEPTH-1:0] inc_vec_s;
    logic [DEPTH-1:0] dec_vec_s;

    // Lookup: matching valid slot, and lowest-index free slot
    always_comb begin
        hit_s        = 1'b0;
        hit_idx_s    = {OUT_ID_W{1'b0}};
        free_found_s = 1'b0;
        free_idx_s   = {OUT_ID_W{1'b0}};
        take_free_s  = 1'b0;
        valid_vec_s  = {DEPTH{1'b0}};
        for (int unsigned i = 32'd0; i < DEPTH; i++) begin
            valid_vec_s[i] = slot_r[i].valid;
            if (slot_r[i].valid && (slot_r[i].id == req_id)) begin
                hit_s     = 1'b1;
                hit_idx_s = to_idx(i);
            end else begin
                hit_s     = hit_s;
            end
            take_free_s  = !slot_r[i].valid && !free_found_s;
            free_idx_s   = take_free_s ? to_idx(i) : free_idx_s;
            free_found_s = free_found_s | take_free_s;
        end
    end

    // Grant and pass-through handshake; grant depends only on table state and ID
    always_comb begin
        grant_s      = hit_s ? (slot_r[hit_idx_s].cnt != CNT_MAX) : free_found_s;
        alloc_idx_s  = hit_s ? hit_idx_s : free_idx_s;
        dn_valid     = req_valid & grant_s;
        req_ready    = dn_ready & grant_s;
        dn_id        = alloc_idx_s;
        alloc_fire_s = req_valid & dn_ready & grant_s;
        rsp_id       = slot_r[cpl_slot].id;
        full         = &valid_vec_s;
    end

    // Per-slot increment/decrement requests; a completion on a count-0 slot is ignored
    always_comb begin
        inc_vec_s = {DEPTH{1'b0}};
        dec_vec_s = {DEPTH{1'b0}};
        for (int unsigned i = 32'd0; i < DEPTH; i++) begin
            inc_vec_s[i] = alloc_fire_s && (alloc_idx_s == to_idx(i));
            dec_vec_s[i] = cpl_fire && (cpl_slot == to_idx(i)) && (slot_r[i].cnt != CNT_ZERO);
        end
    end

    // Next table state; same-slot allocate and free cancel out and keep the slot live
    always_comb begin
        for (int unsigned i = 32'd0; i < DEPTH; i++) begin
            slot_nxt_s[i] = slot_r[i];
            case ({inc_vec_s[i], dec_vec_s[i]})
                2'b10: begin
                    if (slot_r[i].valid) begin
                        slot_nxt_s[i].cnt = slot_r[i].cnt + CNT_ONE;
                    end else begin
                        slot_nxt_s[i].valid = 1'b1;
                        slot_nxt_s[i].id    = req_id;
                        slot_nxt_s[i].cnt   = CNT_ONE;
                    end
                end
                2'b01: begin
                    slot_nxt_s[i].cnt   = slot_r[i].cnt - CNT_ONE;
                    slot_nxt_s[i].valid = (slot_r[i].cnt != CNT_ONE);
                end
                2'b11: slot_nxt_s[i] = slot_r[i];
                2'b00: slot_nxt_s[i] = slot_r[i];
                default: slot_nxt_s[i] = slot_r[i];
            endcase
        end
    end

`ifdef AXI_ID_REMAP_ERR_EN
    // Completion addressed to a slot with nothing outstanding
    always_comb begin
        unmapped = cpl_fire & ~slot_r[cpl_slot].valid;
    end
`endif

    // Table state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 32'd0; i < DEPTH; i++) begin
                slot_r[i] <= SLOT_IDLE;
            end
        end else begin
            slot_r <= slot_nxt_s;
        end
    end

endmodule

// File: rtl/axi_id_remap_table.sv
// axi_id_remap_table: maps wide upstream AXI IDs onto 2**OUT_ID_WIDTH downstream
// slots per direction, restores IDs on R/B and back-pressures AR/AW when no slot
// is available. Optional macro AXI_ID_REMAP_ERR_EN enables the sticky
// err_unmapped flag; without it err_unmapped is tied low.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned IN_ID_WIDTH  = IN_ID_W,
    parameter int unsigned OUT_ID_WIDTH = OUT_ID_W,
    parameter int unsigned CNT_WIDTH    = CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [IN_ID_WIDTH-1:0]  s_arid,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [OUT_ID_WIDTH-1:0] m_arid,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [IN_ID_WIDTH-1:0]  s_awid,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [OUT_ID_WIDTH-1:0] m_awid,
    input  logic                    rvalid,
    input  logic                    rready,
    input  logic                    rlast,
    input  logic [OUT_ID_WIDTH-1:0] m_rid,
    output logic [IN_ID_WIDTH-1:0]  s_rid,
    input  logic                    bvalid,
    input  logic                    bready,
    input  logic [OUT_ID_WIDTH-1:0] m_bid,
    output logic [IN_ID_WIDTH-1:0]  s_bid,
    output logic                    rd_full,
    output logic                    wr_full,
    output logic                    err_unmapped
);

    // The slot record lives in the package, so the widths are fixed there;
    // a mismatching override stops elaboration on a missing module.
    localparam bit CFG_OK = (IN_ID_WIDTH == IN_ID_W) && (OUT_ID_WIDTH == OUT_ID_W) &&
                            (CNT_WIDTH == CNT_W);

    generate
        if (!CFG_OK) begin : g_cfg_mismatch
            axi_id_remap_widths_must_match_pkg u_stop ();
        end
    endgenerate

    logic r_cpl_s;
    logic b_cpl_s;
`ifdef AXI_ID_REMAP_ERR_EN
    logic rd_unmapped_s;
    logic wr_unmapped_s;
    logic err_r;
`endif

    // Completion strobes: last R beat, or any B beat
    always_comb begin
        r_cpl_s = rvalid & rready & rlast;
        b_cpl_s = bvalid & bready;
    end

    axi_id_remap_chan u_rd (
        .clk       (clk),
        .rst       (rst),
        .req_valid (s_arvalid),
        .req_ready (s_arready),
        .req_id    (s_arid),
        .dn_valid  (m_arvalid),
        .dn_ready  (m_arready),
        .dn_id     (m_arid),
        .cpl_fire  (r_cpl_s),
        .cpl_slot  (m_rid),
        .rsp_id    (s_rid),
`ifdef AXI_ID_REMAP_ERR_EN
        .unmapped  (rd_unmapped_s),
`endif
        .full      (rd_full)
    );

    axi_id_remap_chan u_wr (
        .clk       (clk),
        .rst       (rst),
        .req_valid (s_awvalid),
        .req_ready (s_awready),
        .req_id    (s_awid),
        .dn_valid  (m_awvalid),
        .dn_ready  (m_awready),
        .dn_id     (m_awid),
        .cpl_fire  (b_cpl_s),
        .cpl_slot  (m_bid),
        .rsp_id    (s_bid),
`ifdef AXI_ID_REMAP_ERR_EN
        .unmapped  (wr_unmapped_s),
`endif
        .full      (wr_full)
    );

`ifdef AXI_ID_REMAP_ERR_EN
    // Sticky error: set by any completion to a free slot, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (rd_unmapped_s || wr_unmapped_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_unmapped = err_r;
`else
    assign err_unmapped = 1'b0;
`endif

endmodule

// File: tb/tb_axi_id_remap_table.sv
// tb_axi_id_remap_table: directed plan scenarios plus randomized traffic. A
// stimulus task pushes the expected outputs of every cycle into a queue using a
// slot-table reference model; a negedge monitor pops and compares.
module tb_axi_id_remap_table;

    localparam int NS   = 8;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_arvalid, s_arready, m_arvalid, m_arready;
    logic [9:0] s_arid;
    logic [2:0] m_arid;
    logic       s_awvalid, s_awready, m_awvalid, m_awready;
    logic [9:0] s_awid;
    logic [2:0] m_awid;
    logic       rvalid, rready, rlast;
    logic [2:0] m_rid;
    logic [9:0] s_rid;
    logic       bvalid, bready;
    logic [2:0] m_bid;
    logic [9:0] s_bid;
    logic       rd_full, wr_full, err_unmapped;

    axi_id_remap_table dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .m_rid(m_rid), .s_rid(s_rid),
        .bvalid(bvalid), .bready(bready), .m_bid(m_bid), .s_bid(s_bid),
        .rd_full(rd_full), .wr_full(wr_full), .err_unmapped(err_unmapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ar_mv, ar_sr, aw_mv, aw_sr, rd_full, wr_full, r_chk, b_chk, err;
        int ar_id, aw_id, r_id, b_id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: side 0 = read table, side 1 = write table.
    // Stored ID is -1 once a slot has been freed (not observable afterwards).
    int mv   [2][NS];
    int mid  [2][NS];
    int mcnt [2][NS];
    bit merr;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NS; i++) begin
                mv[s][i] = 0; mid[s][i] = 0; mcnt[s][i] = 0;
            end
        merr = 1'b0;
    endfunction

    function automatic void predict(input int s, input int id, output bit g,
                                    output bit hit, output int slot);
        int fr = -1;
        hit = 1'b0; slot = 0;
        for (int i = 0; i < NS; i++) begin
            if (mv[s][i] != 0 && mid[s][i] == id) begin hit = 1'b1; slot = i; end
            if (mv[s][i] == 0 && fr < 0) fr = i;
        end
        if (hit) g = (mcnt[s][slot] < CMAX);
        else begin g = (fr >= 0); slot = (fr >= 0) ? fr : 0; end
    endfunction

    function automatic bit all_valid(input int s);
        for (int i = 0; i < NS; i++) if (mv[s][i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_update(input int s, input bit req, input int id, input bit g,
                                         input bit hit, input int slot, input bit cf, input int cs);
        bit af  = req && g;
        bit dec = cf && (mcnt[s][cs] > 0);
`ifdef AXI_ID_REMAP_ERR_EN
        if (cf && mv[s][cs] == 0) merr = 1'b1;
`endif
        if (af && dec && slot == cs) return;
        if (dec) begin
            mcnt[s][cs]--;
            if (mcnt[s][cs] == 0) begin mv[s][cs] = 0; mid[s][cs] = -1; end
        end
        if (af) begin
            if (hit) mcnt[s][slot]++;
            else begin mv[s][slot] = 1; mid[s][slot] = id; mcnt[s][slot] = 1; end
        end
    endfunction

    // One clock of stimulus: predict outputs, queue them, then advance the model
    task automatic step();
        exp_t e;
        bit   g0, g1, h0, h1;
        int   sl0, sl1;
        bit   rq0, rq1, cf0, cf1;
        int   cs0, cs1, id0, id1;
        if (rst) model_clear();
        id0 = int'(s_arid); id1 = int'(s_awid);
        cs0 = int'(m_rid);  cs1 = int'(m_bid);
        rq0 = s_arvalid && m_arready; rq1 = s_awvalid && m_awready;
        cf0 = rvalid && rready && rlast; cf1 = bvalid && bready;
        predict(0, id0, g0, h0, sl0);
        predict(1, id1, g1, h1, sl1);
        e.ar_mv = s_arvalid && g0; e.ar_sr = m_arready && g0; e.ar_id = sl0;
        e.aw_mv = s_awvalid && g1; e.aw_sr = m_awready && g1; e.aw_id = sl1;
        e.rd_full = all_valid(0);  e.wr_full = all_valid(1);
        e.r_chk = rvalid && (mid[0][cs0] >= 0); e.r_id = mid[0][cs0];
        e.b_chk = bvalid && (mid[1][cs1] >= 0); e.b_id = mid[1][cs1];
        e.err = merr;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            model_update(0, rq0, id0, g0, h0, sl0, cf0, cs0);
            model_update(1, rq1, id1, g1, h1, sl1, cf1, cs1);
        end
        #1;
    endtask

    // Monitor: compare the DUT against the queued expectation every cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("m_arvalid", int'(m_arvalid), int'(mon_e.ar_mv));
            chk("s_arready", int'(s_arready), int'(mon_e.ar_sr));
            if (mon_e.ar_mv) chk("m_arid", int'(m_arid), mon_e.ar_id);
            chk("m_awvalid", int'(m_awvalid), int'(mon_e.aw_mv));
            chk("s_awready", int'(s_awready), int'(mon_e.aw_sr));
            if (mon_e.aw_mv) chk("m_awid", int'(m_awid), mon_e.aw_id);
            chk("rd_full", int'(rd_full), int'(mon_e.rd_full));
            chk("wr_full", int'(wr_full), int'(mon_e.wr_full));
            if (mon_e.r_chk) chk("s_rid", int'(s_rid), mon_e.r_id);
            if (mon_e.b_chk) chk("s_bid", int'(s_bid), mon_e.b_id);
            chk("err_unmapped", int'(err_unmapped), int'(mon_e.err));
        end
    end

    task automatic idle();
        s_arvalid = 1'b0; s_arid = 10'd0; m_arready = 1'b1;
        s_awvalid = 1'b0; s_awid = 10'd0; m_awready = 1'b1;
        rvalid = 1'b0; rready = 1'b1; rlast = 1'b0; m_rid = 3'd0;
        bvalid = 1'b0; bready = 1'b1; m_bid = 3'd0;
    endtask

    task automatic ar(input int id);
        s_arvalid = 1'b1; s_arid = 10'(id); m_arready = 1'b1;
    endtask

    task automatic aw(input int id);
        s_awvalid = 1'b1; s_awid = 10'(id); m_awready = 1'b1;
    endtask

    task automatic rl(input int slot);
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; m_rid = 3'(slot);
    endtask

    task automatic bb(input int slot);
        bvalid = 1'b1; bready = 1'b1; m_bid = 3'(slot);
    endtask

    initial begin
        int pool[12];
        int cand[$];
        for (int k = 0; k < 12; k++) pool[k] = (k * 197 + 13) % 1024;
        model_clear();
        // Reset with traffic presented: pass-through handshake, table empty
        rst = 1'b1;
        idle();
        ar(10'h155); aw(10'h2AA); rl(3); bb(6);
        @(posedge clk); #1;
        step(); step();
        idle();
        step();
        rst = 1'b0;
        step();

        // Single AR then its last R beat; slot 0 reusable afterwards
        ar(10'h155); step(); idle();
        rl(0); step(); idle();
        ar(10'h2AA); step(); idle();
        rl(0); step(); idle();

        // Three outstanding on one ID, freed only after the third completion
        repeat (3) begin ar(10'h001); step(); end
        idle();
        for (int k = 0; k < 3; k++) begin rl(0); ar(10'h3FF); m_arready = 1'b0; step(); end
        idle(); ar(10'h3FF); step(); idle();
        rl(0); step(); idle();

        // Fill all read slots, stall a new ID, free slot 2, retry
        for (int k = 0; k < NS; k++) begin ar(10'h100 + k); step(); end
        ar(10'h0AB); step(); step();
        rl(2); step();
        rvalid = 1'b0; rlast = 1'b0; step();
        idle();
        for (int k = 0; k < NS; k++) begin rl(k); step(); end
        idle();

        // Same-ID allocate and free in one cycle on a count-1 slot
        ar(10'h0C3); step(); idle();
        ar(10'h0C3); rl(0); step(); idle();
        ar(10'h0C4); m_arready = 1'b0; step(); idle();
        rl(0); step(); idle();
        rl(0); step(); idle();

        // Counter saturation on one ID
        repeat (CMAX) begin ar(10'h077); step(); end
        step();
        rl(0); step();
        rvalid = 1'b0; rlast = 1'b0; step();
        idle();
        repeat (CMAX) begin rl(0); step(); end
        idle();

        // Write side fill, stall and release
        for (int k = 0; k < NS; k++) begin aw(10'h200 + k); step(); end
        aw(10'h3C0); step();
        bb(5); step();
        bvalid = 1'b0; step();
        idle();
        for (int k = 0; k < NS; k++) begin bb(k); step(); end
        idle();

        // B on an empty slot, then reset clears the flag
        bb(5); step(); idle();
        step(); step();
        rst = 1'b1; step();
        rst = 1'b0; step();

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            s_arvalid = $urandom_range(0, 1);
            s_arid    = 10'(pool[$urandom_range(0, 11)]);
            m_arready = ($urandom_range(0, 3) != 0);
            s_awvalid = $urandom_range(0, 1);
            s_awid    = 10'(pool[$urandom_range(0, 11)]);
            m_awready = ($urandom_range(0, 3) != 0);
            rvalid    = $urandom_range(0, 1);
            rready    = ($urandom_range(0, 3) != 0);
            rlast     = $urandom_range(0, 1);
            cand.delete();
            for (int i = 0; i < NS; i++) if (mv[0][i] != 0) cand.push_back(i);
            m_rid = (cand.size() > 0 && $urandom_range(0, 9) != 0) ?
                    3'(cand[$urandom_range(0, cand.size() - 1)]) : 3'($urandom_range(0, 7));
            bvalid    = $urandom_range(0, 1);
            bready    = ($urandom_range(0, 3) != 0);
            cand.delete();
            for (int i = 0; i < NS; i++) if (mv[1][i] != 0) cand.push_back(i);
            m_bid = (cand.size() > 0 && $urandom_range(0, 9) != 0) ?
                    3'(cand[$urandom_range(0, cand.size() - 1)]) : 3'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0;
        idle();
        step();
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
